selector_frecuencia: RTL and testbench

- Produces the 3-bit frequency index consumed by the frequency-code memory in the DPWM datapath; this block is the writer side of that index interface.
- Two raw push-buttons (up/down) are synchronized and debounced, then step a saturating index over 0..7.
- Holding a button auto-repeats. A one-cycle pulse flags every index change so downstream logic can reload the PWM period.

---
 rtl/selector_frecuencia_pkg.sv | 7 +
 rtl/selector_frecuencia_antirrebote.sv | 28 ++
 rtl/selector_frecuencia.sv | 60 ++++++
 tb/tb_selector_frecuencia.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/selector_frecuencia_pkg.sv
// selector_frecuencia_pkg: frequency index width and bounds shared across the DPWM datapath
package selector_frecuencia_pkg;
  localparam int IDX_W = 3;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t NUM_MIN = 3'd0;
  localparam idx_t NUM_MAX = 3'd7;
endpackage

// File: rtl/selector_frecuencia_antirrebote.sv
// antirrebote: 2-flop synchronizer followed by a stable-count debouncer
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic reset,
  input  logic in,
  output logic out
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2;
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      out <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (s2 == out) cnt <= '0;
      else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
        out <= ~out;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/selector_frecuencia.sv
// selector_frecuencia: debounced up/down buttons with auto-repeat stepping a saturating 0..7 index
module selector_frecuencia
  import selector_frecuencia_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 20000000,
  parameter int CNT_W           = 26
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output idx_t num_frecuencia,
  output logic cambio,
  output logic en_min,
  output logic en_max
);
  logic [1:0] raw, deb, req;
  logic both, up, dn;
  idx_t num_q;
  assign raw = {btn_down, btn_up};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic prev, rep;
    logic [CNT_W-1:0] hold;
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK(CLK),
      .reset(reset),
      .in(raw[i]),
      .out(deb[i])
    );
    // hold restarts at 1 on every request, so it measures cycles since the last step request
    assign req[i] = deb[i] & (~prev | (hold == (rep ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY))));
    always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
        prev <= 1'b0;
        rep  <= 1'b0;
        hold <= '0;
      end else begin
        prev <= deb[i];
        rep  <= deb[i] & (rep | (req[i] & prev));
        hold <= !deb[i] ? '0 : req[i] ? CNT_W'(1) : hold + 1'b1;
      end
  end
  assign both   = &deb;
  assign up     = req[0] & ~both & (num_frecuencia != NUM_MAX);
  assign dn     = req[1] & ~both & (num_frecuencia != NUM_MIN);
  assign en_min = num_frecuencia == NUM_MIN;
  assign en_max = num_frecuencia == NUM_MAX;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      num_frecuencia <= NUM_MIN;
      num_q          <= NUM_MIN;
      cambio         <= 1'b0;
    end else begin
      num_q          <= num_frecuencia;
      cambio         <= num_frecuencia != num_q;
      num_frecuencia <= up ? num_frecuencia + idx_t'(1) : dn ? num_frecuencia - idx_t'(1) : num_frecuencia;
    end
endmodule

// File: tb/tb_selector_frecuencia.sv
// tb_selector_frecuencia: table, directed and random checks against an event-level reference model
module tb_selector_frecuencia;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  logic CLK = 1'b0, reset = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [2:0] num_frecuencia;
  logic cambio, en_min, en_max;
  int n_chk = 0, n_fail = 0;

  selector_frecuencia #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)) dut (
    .CLK(CLK),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .num_frecuencia(num_frecuencia),
    .cambio(cambio),
    .en_min(en_min),
    .en_max(en_max)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: edge n sees raw(n-2) after synchronization; a level flips after D
  // consecutive disagreeing samples; steps fire at t=0, RD, RD+RR, ... after the rise is seen
  bit hist[2][$];
  int mn, tog[2], midx;
  bit mdeb[2], mchg, mcam;

  function automatic bit rawat(input int b, input int k);
    return (k < 0) ? 1'b0 : hist[b][k];
  endfunction

  always @(posedge CLK or negedge reset)
    if (!reset) begin
      hist[0].delete();
      hist[1].delete();
      mn = 0;
      midx = 0;
      mchg = 0;
      mcam = 0;
      for (int b = 0; b < 2; b++) begin
        mdeb[b] = 0;
        tog[b] = -100;
      end
    end else begin
      bit f[2];
      int nidx;
      hist[0].push_back(btn_up);
      hist[1].push_back(btn_down);
      for (int b = 0; b < 2; b++) begin
        int t;
        t = mn - (tog[b] + 1);
        f[b] = mdeb[b] && t >= 0 && (t == 0 || (t >= RD && (t - RD) % RR == 0));
      end
      nidx = midx;
      if (!(mdeb[0] && mdeb[1])) begin
        if (f[0] && midx < 7) nidx = midx + 1;
        if (f[1] && midx > 0) nidx = midx - 1;
      end
      mcam = mchg;
      mchg = nidx != midx;
      midx = nidx;
      for (int b = 0; b < 2; b++)
        if (mn - tog[b] >= D) begin
          bit all;
          all = 1;
          for (int k = 0; k < D; k++) if (rawat(b, mn - 2 - k) == mdeb[b]) all = 0;
          if (all) begin
            mdeb[b] = !mdeb[b];
            tog[b] = mn;
          end
        end
      mn++;
    end

  always @(negedge CLK)
    if (reset) begin
      chk("model_num", num_frecuencia, midx);
      chk("model_cambio", cambio, mcam);
      chk("model_en_min", en_min, midx == 0);
      chk("model_en_max", en_max, midx == 7);
    end

  typedef struct {
    bit up;
    bit dn;
    int hold;
    int exp_idx;
    int exp_pulses;
  } vec_t;
  vec_t tbl[13];

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic press(input bit u, input bit d, input int h, output int pulses);
    pulses = 0;
    btn_up = u;
    btn_down = d;
    for (int i = 0; i < h + 12; i++) begin
      @(negedge CLK);
      pulses += int'(cambio);
      if (i == h - 1) begin
        btn_up = 1'b0;
        btn_down = 1'b0;
      end
    end
  endtask

  initial begin
    int p, first, nchg;
    int exp_e[5];
    logic [2:0] last;
    tbl[0]  = '{1, 0, 2, 0, 0};
    tbl[1]  = '{1, 0, 3, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 10, 1, 1};
    tbl[4]  = '{1, 0, 4, 2, 1};
    tbl[5]  = '{1, 0, 21, 4, 2};
    tbl[6]  = '{1, 0, 29, 7, 3};
    tbl[7]  = '{1, 0, 10, 7, 0};
    tbl[8]  = '{1, 1, 40, 7, 0};
    tbl[9]  = '{0, 1, 37, 3, 4};
    tbl[10] = '{0, 1, 5, 2, 1};
    tbl[11] = '{0, 1, 30, 0, 2};
    tbl[12] = '{0, 1, 6, 0, 0};
    exp_e = '{7, 27, 35, 43, 51};

    #12;
    chk("rst_num", num_frecuencia, 0);
    chk("rst_cambio", cambio, 0);
    chk("rst_en_min", en_min, 1);
    chk("rst_en_max", en_max, 0);
    reset = 1'b1;

    @(negedge CLK);
    btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      chk("lat_num", num_frecuencia, i >= 7);
      chk("lat_cambio", cambio, i == 8);
      chk("lat_en_min", en_min, i < 7);
    end
    btn_up = 1'b0;
    repeat (12) @(negedge CLK);

    do_reset();
    for (int v = 0; v < 13; v++) begin
      press(tbl[v].up, tbl[v].dn, tbl[v].hold, p);
      chk($sformatf("tbl%0d_idx", v), num_frecuencia, tbl[v].exp_idx);
      chk($sformatf("tbl%0d_pulses", v), p, tbl[v].exp_pulses);
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(1, 0, 5, p);
      chk("up_seq_idx", num_frecuencia, (i + 1 > 7) ? 7 : i + 1);
      chk("up_seq_pulses", p, i < 7);
    end
    chk("up_seq_en_max", en_max, 1);
    for (int i = 0; i < 8; i++) begin
      press(0, 1, 5, p);
      chk("dn_seq_idx", num_frecuencia, (6 - i < 0) ? 0 : 6 - i);
      chk("dn_seq_pulses", p, i < 7);
    end
    chk("dn_seq_en_min", en_min, 1);

    do_reset();
    btn_up = 1'b1;
    last = num_frecuencia;
    nchg = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge CLK);
      if (i == 52) btn_up = 1'b0;
      if (num_frecuencia !== last) begin
        if (nchg < 5) chk("rep_edge", i, exp_e[nchg]);
        nchg++;
        last = num_frecuencia;
      end
    end
    chk("rep_count", nchg, 5);
    chk("rep_idx", num_frecuencia, 5);

    do_reset();
    repeat (3) press(1, 0, 5, p);
    chk("both_start", num_frecuencia, 3);
    btn_up = 1'b1;
    btn_down = 1'b1;
    p = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      p += int'(cambio);
    end
    chk("both_idx", num_frecuencia, 3);
    chk("both_pulses", p, 0);
    btn_down = 1'b0;
    first = -1;
    for (int i = 41; i <= 90 && first < 0; i++) begin
      @(negedge CLK);
      if (num_frecuencia !== 3'd3) first = i;
    end
    chk("both_resume_edge", first, 51);
    chk("both_resume_idx", num_frecuencia, 4);
    btn_up = 1'b0;
    repeat (12) @(negedge CLK);

    do_reset();
    btn_up = 1'b1;
    repeat (53) @(negedge CLK);
    chk("arst_pre_idx", num_frecuencia, 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_num", num_frecuencia, 0);
    chk("arst_cambio", cambio, 0);
    chk("arst_en_min", en_min, 1);
    chk("arst_en_max", en_max, 0);
    repeat (3) @(negedge CLK);
    #2 reset = 1'b1;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      @(posedge CLK);
      #1;
      if (num_frecuencia !== 3'd0) first = i;
    end
    chk("arst_relatch_edge", first, 7);
    @(negedge CLK);
    btn_up = 1'b0;
    repeat (12) @(negedge CLK);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) btn_up = ~btn_up;
      if ($urandom_range(9) == 0) btn_down = ~btn_down;
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (20) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
